// File: rtl/pc_lut_rev.sv
// Reverse lookup for the branch-target LUT: maps a 10-bit PC target back to the
// lowest LUT index holding it, using a one-entry-per-cycle scan behind valid/ready.
module pc_lut_rev #(
   parameter int D       = 10,
   parameter int A       = 8,
   parameter int ENTRIES = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         wr_en,
   input  logic [A-1:0] wr_idx,
   input  logic [D-1:0] wr_target,
   input  logic         req_valid,
   output logic         req_ready,
   input  logic [D-1:0] req_target,
   output logic         rsp_valid,
   output logic         rsp_hit,
   output logic [A-1:0] rsp_idx,
   input  logic         rsp_ready
);

   localparam int         IW        = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
   localparam logic [A:0] ENTRIES_W = (A+1)'(ENTRIES);
   localparam logic [A-1:0] LAST    = A'(ENTRIES - 1);
   localparam logic [A-1:0] ONE     = A'(1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t          state_r;
   logic [A-1:0]    ptr_r;
   logic [D-1:0]    key_r;
   logic            req_ready_r;
   logic            rsp_valid_r;
   logic            rsp_hit_r;
   logic [A-1:0]    rsp_idx_r;

   logic [ENTRIES-1:0] valid_r;
   logic [D-1:0]       target_r [ENTRIES];

   logic            wr_ok_s;
   logic [IW-1:0]   wr_slot_s;
   logic [IW-1:0]   ptr_slot_s;
   logic            hit_s;

   // Decode write legality and the compare of the entry under the scan pointer.
   always_comb begin
      wr_ok_s    = 1'b0;
      wr_slot_s  = wr_idx[IW-1:0];
      ptr_slot_s = ptr_r[IW-1:0];
      hit_s      = 1'b0;
      if (wr_en && ({1'b0, wr_idx} < ENTRIES_W)) begin
         wr_ok_s = 1'b1;
      end else begin
         wr_ok_s = 1'b0;
      end
      // Compare sees only contents registered before this edge.
      if (valid_r[ptr_slot_s] && (target_r[ptr_slot_s] == key_r)) begin
         hit_s = 1'b1;
      end else begin
         hit_s = 1'b0;
      end
   end

   // Target table storage; writes land in any FSM state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_r <= {ENTRIES{1'b0}};
         for (int i = 0; i < ENTRIES; i++) begin
            target_r[i] <= {D{1'b0}};
         end
      end else if (wr_ok_s) begin
         valid_r[wr_slot_s]  <= 1'b1;
         target_r[wr_slot_s] <= wr_target;
      end
   end

   // Lookup FSM with registered handshake and response outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         ptr_r       <= {A{1'b0}};
         key_r       <= {D{1'b0}};
         req_ready_r <= 1'b1;
         rsp_valid_r <= 1'b0;
         rsp_hit_r   <= 1'b0;
         rsp_idx_r   <= {A{1'b0}};
      end else begin
         case (state_r)
            IDLE: begin
               if (req_valid) begin
                  key_r       <= req_target;
                  ptr_r       <= {A{1'b0}};
                  req_ready_r <= 1'b0;
                  state_r     <= SCAN;
               end
            end
            SCAN: begin
               if (hit_s) begin
                  rsp_hit_r   <= 1'b1;
                  rsp_idx_r   <= ptr_r;
                  rsp_valid_r <= 1'b1;
                  state_r     <= RESP;
               end else if (ptr_r == LAST) begin
                  rsp_hit_r   <= 1'b0;
                  rsp_idx_r   <= {A{1'b0}};
                  rsp_valid_r <= 1'b1;
                  state_r     <= RESP;
               end else begin
                  ptr_r <= ptr_r + ONE;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid_r <= 1'b0;
                  rsp_hit_r   <= 1'b0;
                  rsp_idx_r   <= {A{1'b0}};
                  ptr_r       <= {A{1'b0}};
                  req_ready_r <= 1'b1;
                  state_r     <= IDLE;
               end
            end
            default: begin
               state_r     <= IDLE;
               ptr_r       <= {A{1'b0}};
               req_ready_r <= 1'b1;
               rsp_valid_r <= 1'b0;
               rsp_hit_r   <= 1'b0;
               rsp_idx_r   <= {A{1'b0}};
            end
         endcase
      end
   end

   assign req_ready = req_ready_r;
   assign rsp_valid = rsp_valid_r;
   assign rsp_hit   = rsp_hit_r;
   assign rsp_idx   = rsp_idx_r;

endmodule

// File: tb/tb_pc_lut_rev.sv
// Directed bench for pc_lut_rev: hits, misses, duplicates, write/scan races,
// handshake hold, out-of-range writes and mid-scan reset.
module tb_pc_lut_rev;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       wr_en;
   logic [7:0] wr_idx;
   logic [9:0] wr_target;
   logic       req_valid;
   logic       req_ready;
   logic [9:0] req_target;
   logic       rsp_valid;
   logic       rsp_hit;
   logic [7:0] rsp_idx;
   logic       rsp_ready;

   int n_assert = 0;
   int n_fail   = 0;

   pc_lut_rev #(.D(10), .A(8), .ENTRIES(32)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .wr_en      (wr_en),
      .wr_idx     (wr_idx),
      .wr_target  (wr_target),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_target (req_target),
      .rsp_valid  (rsp_valid),
      .rsp_hit    (rsp_hit),
      .rsp_idx    (rsp_idx),
      .rsp_ready  (rsp_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic do_write(input int idx, input int tgt);
      @(negedge clk);
      wr_en     = 1'b1;
      wr_idx    = 8'(idx);
      wr_target = 10'(tgt);
      @(negedge clk);
      wr_en     = 1'b0;
   endtask

   // Issue one lookup, optionally writing at scan steps w1_n / w2_n, and check
   // latency, result, stability over 'hold' stalled cycles and the return to IDLE.
   task automatic lookup(input string tag, input int key, input logic exp_hit,
                         input int exp_idx, input int exp_lat, input int hold,
                         input int w1_n, input int w1_idx, input int w1_tgt,
                         input int w2_n, input int w2_idx, input int w2_tgt);
      int n;
      @(negedge clk);
      chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
      req_valid  = 1'b1;
      req_target = 10'(key);
      @(negedge clk);
      req_valid = 1'b0;
      n = 0;
      while (!rsp_valid && n < 200) begin
         if (n == w1_n) begin
            wr_en = 1'b1; wr_idx = 8'(w1_idx); wr_target = 10'(w1_tgt);
         end else if (n == w2_n) begin
            wr_en = 1'b1; wr_idx = 8'(w2_idx); wr_target = 10'(w2_tgt);
         end else begin
            wr_en = 1'b0;
         end
         @(negedge clk);
         n++;
      end
      wr_en = 1'b0;
      chk({tag, "_latency"}, 32'(n), 32'(exp_lat));
      chk({tag, "_hit"}, 32'(rsp_hit), 32'(exp_hit));
      chk({tag, "_idx"}, 32'(rsp_idx), 32'(exp_idx));
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk({tag, "_hold_valid"}, 32'(rsp_valid), 32'd1);
         chk({tag, "_hold_hit"}, 32'(rsp_hit), 32'(exp_hit));
         chk({tag, "_hold_idx"}, 32'(rsp_idx), 32'(exp_idx));
         chk({tag, "_hold_ready"}, 32'(req_ready), 32'd0);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk({tag, "_done_valid"}, 32'(rsp_valid), 32'd0);
      chk({tag, "_done_ready"}, 32'(req_ready), 32'd1);
   endtask

   int tbl [17] = '{0, 3, 11, 12, 47, 86, 89, 99, 100, 138, 153, 178, 189, 231, 281, 323, 4};

   initial begin
      rst_n = 1'b0; wr_en = 1'b0; wr_idx = 8'd0; wr_target = 10'd0;
      req_valid = 1'b0; req_target = 10'd0; rsp_ready = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_hit", 32'(rsp_hit), 32'd0);
      chk("rst_rsp_idx", 32'(rsp_idx), 32'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 17; i++) do_write(i, tbl[i]);
      lookup("hit323", 323, 1'b1, 15, 16, 0, -1, 0, 0, -1, 0, 0);
      lookup("hit4", 4, 1'b1, 16, 17, 0, -1, 0, 0, -1, 0, 0);
      lookup("miss500", 500, 1'b0, 0, 32, 0, -1, 0, 0, -1, 0, 0);

      do_write(2, 153);
      do_write(9, 153);
      lookup("dup_lo", 153, 1'b1, 2, 3, 0, -1, 0, 0, -1, 0, 0);
      do_write(2, 0);
      lookup("dup_hi", 153, 1'b1, 9, 10, 0, -1, 0, 0, -1, 0, 0);

      // Index 40 would alias onto entry 8 if the bound were not enforced.
      do_write(40, 500);
      lookup("oob_miss", 500, 1'b0, 0, 32, 0, -1, 0, 0, -1, 0, 0);
      lookup("oob_keep8", 100, 1'b1, 8, 9, 10, -1, 0, 0, -1, 0, 0);

      lookup("race_at_ptr", 77, 1'b0, 0, 32, 0, 5, 5, 77, -1, 0, 0);
      do_write(5, 86);
      lookup("race_ahead", 77, 1'b1, 20, 21, 0, 3, 20, 77, 5, 5, 77);

      @(negedge clk);
      req_valid = 1'b1; req_target = 10'd4;
      @(negedge clk);
      req_valid = 1'b0;
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst_req_ready", 32'(req_ready), 32'd1);
      chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("midrst_rsp_hit", 32'(rsp_hit), 32'd0);
      chk("midrst_rsp_idx", 32'(rsp_idx), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      lookup("cleared_miss0", 0, 1'b0, 0, 32, 0, -1, 0, 0, -1, 0, 0);
      lookup("cleared_miss4", 4, 1'b0, 0, 32, 0, -1, 0, 0, -1, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/pc_lut_rev.md
# pc_lut_rev

Reverse-lookup companion to the branch-target LUT: given a 10-bit PC target, returns the LUT index that produces it. Holds a runtime-writable table of up to 32 targets and resolves each lookup by a sequential one-entry-per-cycle scan behind a valid/ready handshake. It sits beside the fetch unit and is used by the program loader and debug logic to encode absolute branch targets into LUT indices.

## Interface

**Parameters**
- D, 10: width of a PC target.
- A, 8: width of a LUT index.
- ENTRIES, 32: number of table entries; must satisfy 2 ≤ ENTRIES ≤ 2^A.

**Ports**
- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- wr_en  in  1  writes wr_target into entry wr_idx and marks that entry valid.
- wr_idx  in  A  entry to write. A write with wr_idx ≥ ENTRIES is ignored.
- wr_target  in  D  target value to store.
- req_valid  in  1  lookup request is present.
- req_ready  out  1  block can accept a lookup. It is high only in IDLE.
- req_target  in  D  PC target to search for; sampled on acceptance.
- rsp_valid  out  1  a lookup result is present.
- rsp_hit  out  1  result: 1 means found, 0 means miss.
- rsp_idx  out  A  lowest matching index on a hit; 0 on a miss.
- rsp_ready  in  1  consumer accepts the result.

## Operation

- Table state: ENTRIES × {valid, D-bit target}.
  - Reset clears every valid bit and every target to 0.
  - Writes are accepted in any FSM state.
- FSM states: IDLE, SCAN, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid: latch req_target into key, set ptr = 0, go to SCAN.
- SCAN (one entry per cycle):
  - Compare entry[ptr] with key.
  - If valid[ptr] && target[ptr] == key: rsp_hit = 1, rsp_idx = ptr, go to RESP.
  - Else if ptr == ENTRIES-1: rsp_hit = 0, rsp_idx = 0, go to RESP.
  - Else: ptr = ptr + 1.
- RESP:
  - rsp_valid = 1; rsp_hit and rsp_idx are held stable.
  - On rsp_ready: go to IDLE and drop rsp_valid.
  - No new request is accepted in the same cycle.
- Duplicate targets: the lowest index wins, because the scan is in ascending order.
- Write/scan interaction:
  - The comparison in a cycle uses the table contents registered before that edge.
  - A write to entry[ptr] in the same cycle is not seen by that comparison.
  - A write to a higher, not-yet-scanned entry is seen when the scan reaches it.
  - Writes during RESP never alter the held response.
- Width rules:
  - ptr is A bits and never exceeds ENTRIES-1.
  - The compare is a full D-bit equality; no partial match.
- Reset mid-operation (any state):
  - Immediate return to IDLE.
  - rsp_valid = 0, rsp_hit = 0, rsp_idx = 0, ptr = 0.
  - The table is cleared, and any in-flight lookup is dropped.

## Timing

- Output reset values: req_ready = 1 (IDLE), rsp_valid = 0, rsp_hit = 0, rsp_idx = 0.
- All outputs are registered or decoded from state only; there is no combinational path from inputs to outputs.
- Write latency: a write on edge E is visible to comparisons from edge E+1.
- Lookup latency, with acceptance at edge E0:
  - Hit at index k: rsp_valid is high after edge E0+k+1.
  - Miss: rsp_valid is high after edge E0+ENTRIES.
- Back-to-back lookups: the minimum spacing is latency + 1 cycle. RESP → IDLE takes one edge before req_ready returns.
- rsp_ready held high in advance: RESP lasts exactly one cycle.

## Test plan

- **Reset:** rst_n low mid-SCAN with a request in flight → all outputs read their reset values immediately; after release, req_ready = 1 and a lookup of 0 misses (table cleared).
- **Basic hit:**
  - Stimulus: write entries 0..16 = {0,3,11,12,47,86,89,99,100,138,153,178,189,231,281,323,4}, then look up 323.
  - Required response: rsp_hit = 1, rsp_idx = 15, rsp_valid rising 16 cycles after acceptance.
  - Then look up 4: rsp_idx = 16.
- **Miss:** same table, look up 500 → rsp_hit = 0, rsp_idx = 0, rsp_valid exactly 32 cycles after acceptance.
- **Duplicates:** entries 2 and 9 both set to 153; look up 153 → rsp_idx = 2. Rewrite entry 2 to 0, look up again → rsp_idx = 9.
- **Write/scan race:**
  - Start a lookup of 77.
  - Write 77 to entry 5 in the cycle ptr = 5 → scan does not match at 5; result is a miss (or a hit at a later entry if 77 is stored there).
  - Write 77 to entry 20 while ptr = 3 → hit, rsp_idx = 20.
- **Handshake and bounds:**
  - Hold rsp_ready low for 10 cycles → rsp_valid, rsp_hit and rsp_idx stay stable and req_ready stays 0.
  - A write with wr_idx = 40 leaves the table unchanged.
  - Release rsp_ready → req_ready rises the next cycle.
